fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/fetch_queue.sv | 91 +++++++++
 tb/tb_fetch_queue.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch queue.
// No logic lives here.
package fetch_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of {addr, data}; head is visible the cycle after a push.
// Flush empties it and wins over push/pop; a push into a full FIFO is dropped unless a pop frees a slot.
module fetch_fifo #(
    parameter int W     = 43,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // Storage needs no reset: the head is only looked at while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential RAM reads and buffers {pc, word}; issue-to-valid is 2 cycles.
// Backpressure: issue stalls while queued plus in-flight reads would exceed DEPTH; redirect flushes everything.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_en,
    output logic                       ram_rd_en1,
    output logic [ADDR_W-1:0]          ram_addr1,
    input  logic [DATA_W-1:0]          ram_data1,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr_out,
    output logic [ADDR_W-1:0]          instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = ADDR_W + DATA_W;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pend_pc;
    logic              pend;
    logic              flush;
    logic              push;
    logic              pop;
    logic [EW-1:0]     head;
    logic [CW:0]       occupancy;

    // RAM latency is exactly one cycle, so at most one read is ever in flight.
    assign occupancy   = {1'b0, count} + {{CW{1'b0}}, pend};
    assign ram_rd_en1  = (state == RUN) && fetch_en && !redirect
                         && (occupancy < (CW+1)'(DEPTH));
    assign ram_addr1   = fetch_pc;

    assign flush       = redirect && (state == RUN);
    assign push        = pend && !flush;
    assign pop         = instr_valid && instr_ready && !flush;

    assign instr_valid = (count != '0);
    assign instr_pc    = instr_valid ? head[EW-1:DATA_W] : '0;
    assign instr_out   = instr_valid ? head[DATA_W-1:0]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            fetch_pc <= ADDR_W'(RESET_PC);
            pend     <= 1'b0;
            pend_pc  <= '0;
        end else begin
            case (state)
                IDLE:    if (fetch_en)  state <= RUN;
                RUN:     if (!fetch_en) state <= IDLE;
                default: state <= IDLE;
            endcase
            pend <= ram_rd_en1;
            if (ram_rd_en1) begin
                pend_pc <= fetch_pc;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
            end else if (ram_rd_en1) begin
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

    fetch_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({pend_pc, ram_data1}),
        .pop      (pop),
        .flush    (flush),
        .head     (head),
        .count    (count)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;

    localparam int DW = 32;
    localparam int AW = 11;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic          ram_rd_en1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_data1 = '0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid;
    logic [DW-1:0] instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic [2:0]    count;

    fetch_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .ram_rd_en1  (ram_rd_en1),
        .ram_addr1   (ram_addr1),
        .ram_data1   (ram_data1),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .count       (count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {{(DW-AW){1'b0}}, a} + 32'h100;
    endfunction

    // Instruction RAM: data valid one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        ram_data1 <= ram_rd_en1 ? ram_word(ram_addr1) : $urandom;
    end

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] dat;
    } ent_t;

    ent_t          mq[$];
    bit            m_run;
    logic [AW-1:0] m_pc;
    bit            m_inf;
    logic [AW-1:0] m_inf_pc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic          obs_rd_en;
    logic [AW-1:0] obs_addr;
    logic          obs_valid;
    logic [AW-1:0] obs_ipc;
    logic [DW-1:0] obs_iout;
    logic [2:0]    obs_count;

    task automatic model_reset();
        mq.delete();
        m_run = 0;
        m_pc = '0;
        m_inf = 0;
        m_inf_pc = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fetch_en = 1'b0;
        redirect = 1'b0;
        instr_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive inputs, compare DUT against the model, then advance the model.
    task automatic step(input logic fe, input logic rd, input logic [AW-1:0] rpc, input logic rdy);
        logic          e_issue;
        logic          e_valid;
        logic [AW-1:0] e_ipc;
        logic [DW-1:0] e_iout;
        ent_t          e;
        @(negedge clk);
        fetch_en = fe;
        redirect = rd;
        redirect_pc = rpc;
        instr_ready = rdy;
        #1;
        e_valid = mq.size() > 0;
        e_ipc   = e_valid ? mq[0].pc : '0;
        e_iout  = e_valid ? mq[0].dat : '0;
        e_issue = m_run && fe && !rd && ((mq.size() + int'(m_inf)) < D);
        checks += 6;
        if (ram_rd_en1 !== e_issue) begin
            errors++; $display("FAIL rd_en cyc=%0d got %0b expected %0b", cyc, ram_rd_en1, e_issue);
        end
        if (ram_addr1 !== m_pc) begin
            errors++; $display("FAIL ram_addr cyc=%0d got %0h expected %0h", cyc, ram_addr1, m_pc);
        end
        if (instr_valid !== e_valid) begin
            errors++; $display("FAIL instr_valid cyc=%0d got %0b expected %0b", cyc, instr_valid, e_valid);
        end
        if (instr_pc !== e_ipc) begin
            errors++; $display("FAIL instr_pc cyc=%0d got %0h expected %0h", cyc, instr_pc, e_ipc);
        end
        if (instr_out !== e_iout) begin
            errors++; $display("FAIL instr_out cyc=%0d got %0h expected %0h", cyc, instr_out, e_iout);
        end
        if (count !== 3'(mq.size())) begin
            errors++; $display("FAIL count cyc=%0d got %0d expected %0d", cyc, count, mq.size());
        end
        obs_rd_en = ram_rd_en1;
        obs_addr  = ram_addr1;
        obs_valid = instr_valid;
        obs_ipc   = instr_pc;
        obs_iout  = instr_out;
        obs_count = count;
        @(posedge clk);
        if (rd && m_run) begin
            mq.delete();
        end else begin
            if (e_valid && rdy) void'(mq.pop_front());
            if (m_inf) begin
                e.pc = m_inf_pc;
                e.dat = ram_word(m_inf_pc);
                mq.push_back(e);
            end
        end
        m_inf = e_issue;
        m_inf_pc = m_pc;
        if (rd) m_pc = rpc;
        else if (e_issue) m_pc = m_pc + 1'b1;
        m_run = fe;
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ram_rd_en1, ram_addr1, instr_valid, instr_out, instr_pc, count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%0b addr=%0h v=%0b out=%0h pc=%0h cnt=%0d expected all 0",
                     ram_rd_en1, ram_addr1, instr_valid, instr_out, instr_pc, count);
        end
        do_reset();
        repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_fill();
        logic [AW-1:0] addrs[$];
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (obs_rd_en) addrs.push_back(obs_addr);
        end
        checks++;
        if (addrs.size() != 4) begin
            errors++; $display("FAIL fill_reads got %0d expected 4", addrs.size());
        end
        for (int i = 0; i < addrs.size() && i < 4; i++) begin
            checks++;
            if (addrs[i] !== AW'(i)) begin
                errors++; $display("FAIL fill_addr%0d got %0h expected %0h", i, addrs[i], i);
            end
        end
        checks++;
        if (obs_count !== 3'd4 || obs_iout !== 32'h100 || obs_ipc !== '0) begin
            errors++;
            $display("FAIL fill_head got cnt=%0d out=%0h pc=%0h expected cnt=4 out=100 pc=0",
                     obs_count, obs_iout, obs_ipc);
        end
    endtask

    task automatic test_stream();
        int first_rd = -1;
        int first_v = -1;
        logic [AW-1:0] next_pc = '0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (obs_rd_en && first_rd < 0) first_rd = i;
            if (obs_valid) begin
                if (first_v < 0) first_v = i;
                checks++;
                if (obs_ipc !== next_pc) begin
                    errors++; $display("FAIL stream_order got %0h expected %0h", obs_ipc, next_pc);
                end
                next_pc = next_pc + 1'b1;
            end
        end
        checks++;
        if (first_rd < 0 || first_v - first_rd != 2) begin
            errors++; $display("FAIL stream_latency got %0d expected 2", first_v - first_rd);
        end
        checks++;
        if (next_pc < AW'(20)) begin
            errors++; $display("FAIL stream_rate got %0d instrs expected >= 20", next_pc);
        end
    endtask

    task automatic test_redirect();
        bit found = 0;
        bit seen = 0;
        logic [AW-1:0] first_pc = '0;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (obs_rd_en && obs_addr == AW'(5)) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL redirect_setup got no read of 5 expected one within 20 cycles");
        end
        step(1'b1, 1'b1, AW'(11'h40), 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (obs_valid) begin
                if (!seen) first_pc = obs_ipc;
                seen = 1;
                checks++;
                if (obs_ipc === AW'(5)) begin
                    errors++; $display("FAIL redirect_stale got pc %0h expected never 5", obs_ipc);
                end
            end
        end
        checks++;
        if (!seen || first_pc !== AW'(11'h40)) begin
            errors++; $display("FAIL redirect_target got %0h expected 40", first_pc);
        end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] addrs[$];
        do_reset();
        step(1'b0, 1'b1, AW'(11'h7FF), 1'b0);
        for (int i = 0; i < 10 && addrs.size() < 2; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
            if (obs_rd_en) addrs.push_back(obs_addr);
        end
        checks++;
        if (addrs.size() < 2 || addrs[0] !== AW'(11'h7FF) || addrs[1] !== '0) begin
            errors++; $display("FAIL wrap_addrs got %0d reads first=%0h expected 7ff then 0",
                               addrs.size(), addrs.size() > 0 ? addrs[0] : '0);
        end
        repeat (8) step(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_midread();
        bit found = 0;
        do_reset();
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            if (obs_rd_en) found = 1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!found || {ram_rd_en1, ram_addr1, instr_valid, instr_out, instr_pc, count} !== '0) begin
            errors++; $display("FAIL midread_reset got v=%0b cnt=%0d rd=%0b expected all 0",
                               instr_valid, count, ram_rd_en1);
        end
        model_reset();
        fetch_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step(1'b0, 1'b0, '0, 1'b0);
        repeat (6) step(1'b1, 1'b0, '0, 1'b1);
    endtask

    task automatic test_fetch_stop();
        int reads = 0;
        int guard = 0;
        do_reset();
        while (mq.size() != 2 && guard < 20) begin
            step(1'b1, 1'b0, '0, 1'b0);
            guard++;
        end
        checks++;
        if (guard >= 20) begin
            errors++; $display("FAIL stop_setup got count %0d expected 2 within 20 cycles", count);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            if (obs_rd_en) reads++;
        end
        checks++;
        if (reads != 0 || obs_count !== 3'd3) begin
            errors++; $display("FAIL stop_hold got reads=%0d cnt=%0d expected reads=0 cnt=3", reads, obs_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 8) != 0, ($urandom % 16) == 0, AW'($urandom), $urandom % 2);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_wrap();
        test_reset_midread();
        test_fetch_stop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
